alu_sched: RTL and testbench

Multi-requester issue controller for the 32-bit ALU. It arbitrates round-robin among `NREQ` requesters, validates the 5-bit opcode, and drives the ALU's `opcode`/`a`/`b`/`enable` inputs for the ALU's fixed latency. It captures `out` and returns the result, tagged with the requester ID, over a valid/ready response channel. It sits between the instruction-issue logic and the ALU instance, and only one operation is in flight at a time.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_sched_if.sv | 41 ++++
 rtl/alu_sched_rr_arbiter.sv | 32 +++
 rtl/alu_sched.sv | 140 ++++++++++++++
 tb/tb_alu_sched.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, scheduler state type and operand payload for the
// ALU issue scheduler.
package alu_pkg;

   localparam int unsigned OPC_W  = 5;
   localparam int unsigned DATA_W = 32;

   localparam logic [OPC_W-1:0] OP_AND  = 5'd8;
   localparam logic [OPC_W-1:0] OP_OR   = 5'd9;
   localparam logic [OPC_W-1:0] OP_XOR  = 5'd10;
   localparam logic [OPC_W-1:0] OP_NAND = 5'd11;
   localparam logic [OPC_W-1:0] OP_NOR  = 5'd12;
   localparam logic [OPC_W-1:0] OP_XNOR = 5'd13;

   localparam logic [OPC_W-1:0] OP_LEGAL_LO = OP_AND;
   localparam logic [OPC_W-1:0] OP_LEGAL_HI = OP_XNOR;

   localparam int unsigned ALU_LAT_DEFAULT = 2;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } sched_state_t;

   typedef struct packed {
      logic [OPC_W-1:0]  opcode;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } alu_op_t;

   function automatic logic op_legal(input logic [OPC_W-1:0] op);
      return (op >= OP_LEGAL_LO) && (op <= OP_LEGAL_HI);
   endfunction

endpackage

// File: rtl/alu_sched_if.sv
// Request, ALU-side and response signals of the ALU issue scheduler.
interface alu_sched_if
   import alu_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);

   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ*OPC_W-1:0]  req_opcode;
   logic [NREQ*DATA_W-1:0] req_a;
   logic [NREQ*DATA_W-1:0] req_b;

   logic [OPC_W-1:0]       alu_opcode;
   logic [DATA_W-1:0]      alu_a;
   logic [DATA_W-1:0]      alu_b;
   logic                   alu_enable;
   logic [DATA_W-1:0]      alu_out;

   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [IDW-1:0]         rsp_id;
   logic [DATA_W-1:0]      rsp_data;
   logic                   rsp_err;

   // Environment side: requesters, ALU instance and response consumer.
   modport master (
      output req_valid, req_opcode, req_a, req_b, alu_out, rsp_ready,
      input  req_ready, alu_opcode, alu_a, alu_b, alu_enable,
             rsp_valid, rsp_id, rsp_data, rsp_err
   );

   // Scheduler side.
   modport slave (
      input  req_valid, req_opcode, req_a, req_b, alu_out, rsp_ready,
      output req_ready, alu_opcode, alu_a, alu_b, alu_enable,
             rsp_valid, rsp_id, rsp_data, rsp_err
   );

endinterface

// File: rtl/alu_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after ptr, wrapping from NREQ-1 back to 0.
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id
);

   logic [IDW-1:0] idx;
   logic           found;

   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      idx    = '0;
      found  = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = IDW'((32'(ptr) + k) % NREQ);
         if (en && !found && req[idx]) begin
            found      = 1'b1;
            gnt[idx]   = 1'b1;
            gnt_id     = idx;
         end
      end
   end

endmodule

// File: rtl/alu_sched.sv
// Single-issue ALU scheduler: round-robin request arbitration, opcode check,
// fixed-latency ALU drive and tagged valid/ready response.
module alu_sched
   import alu_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned ALU_LAT = ALU_LAT_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   alu_sched_if.slave bus,
   output logic       busy
);

   localparam int unsigned IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   sched_state_t      state_q, state_d;
   logic [IDW-1:0]    rr_q, rr_d;
   logic [IDW-1:0]    id_q, id_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   alu_op_t           op_q, op_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              err_q, err_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              alu_en_q, alu_en_d;
   logic              busy_q, busy_d;

   logic [NREQ-1:0]   gnt;
   logic [IDW-1:0]    gnt_id;
   alu_op_t           req_sel;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req    (bus.req_valid),
      .ptr    (rr_q),
      .en     (state_q == IDLE),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   assign req_sel.opcode = bus.req_opcode[int'(gnt_id)*OPC_W +: OPC_W];
   assign req_sel.a      = bus.req_a[int'(gnt_id)*DATA_W +: DATA_W];
   assign req_sel.b      = bus.req_b[int'(gnt_id)*DATA_W +: DATA_W];

   // Next state, latency counter, operand and response registers.
   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      id_d        = id_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      data_d      = data_q;
      err_d       = err_q;
      rsp_valid_d = rsp_valid_q;
      alu_en_d    = alu_en_q;
      busy_d      = busy_q;
      unique case (state_q)
         IDLE: begin
            if (|gnt) begin
               id_d   = gnt_id;
               rr_d   = (32'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
               busy_d = 1'b1;
               if (op_legal(req_sel.opcode)) begin
                  op_d     = req_sel;
                  cnt_d    = CNT_W'(ALU_LAT - 1);
                  alu_en_d = 1'b1;
                  state_d  = EXEC;
               end else begin
                  data_d      = '0;
                  err_d       = 1'b1;
                  rsp_valid_d = 1'b1;
                  state_d     = RESP;
               end
            end
         end
         EXEC: begin
            if (cnt_q == '0) begin
               data_d      = bus.alu_out;
               err_d       = 1'b0;
               alu_en_d    = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               busy_d      = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            alu_en_d    = 1'b0;
            busy_d      = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_q        <= '0;
         id_q        <= '0;
         cnt_q       <= '0;
         op_q        <= '0;
         data_q      <= '0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         alu_en_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         id_q        <= id_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         data_q      <= data_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
         alu_en_q    <= alu_en_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.req_ready  = gnt;
   assign bus.alu_opcode = op_q.opcode;
   assign bus.alu_a      = op_q.a;
   assign bus.alu_b      = op_q.b;
   assign bus.alu_enable = alu_en_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = id_q;
   assign bus.rsp_data   = data_q;
   assign bus.rsp_err    = err_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: directed scenarios plus random traffic, checked every
// cycle against a transaction-timeline reference model.
module tb_alu_sched;
   import alu_pkg::*;

   localparam int unsigned NREQ    = 4;
   localparam int unsigned ALU_LAT = 2;

   logic clk = 1'b0;
   logic rst;
   logic busy;

   always #5 clk = ~clk;

   alu_sched_if #(.NREQ(NREQ)) bus ();

   alu_sched #(.NREQ(NREQ), .ALU_LAT(ALU_LAT)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      case (op)
         5'd8:    return a & b;
         5'd9:    return a | b;
         5'd10:   return a ^ b;
         5'd11:   return ~(a & b);
         5'd12:   return ~(a | b);
         5'd13:   return ~(a ^ b);
         default: return 32'h0;
      endcase
   endfunction

   // ALU stand-in: result appears one cycle after an enabled cycle.
   always @(posedge clk) bus.alu_out <= bus.alu_enable ? ref_alu(bus.alu_opcode, bus.alu_a, bus.alu_b)
                                                       : 32'hDEAD_BEEF;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Requester-held requests
   bit          pend_v  [NREQ];
   logic [4:0]  pend_op [NREQ];
   logic [31:0] pend_a  [NREQ];
   logic [31:0] pend_b  [NREQ];

   // Reference model: one op in flight, described by its accept cycle
   int          cyc = 0;
   int          rr_m = 0;
   bit          inflight = 0;
   int          acc_cyc = 0;
   bit          m_legal = 0;
   int          m_id = 0;
   logic [31:0] m_data = '0;
   logic [4:0]  last_op = '0;
   logic [31:0] last_a = '0, last_b = '0;

   // Stimulus controls
   bit rand_fill = 0;
   bit refill_xor = 0;
   int rdy_mode = 0;
   int stall_cnt = 0;
   int grant_log[$];
   int rsp_log[$];

   task automatic set_req(input int i, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      pend_v[i]  = 1'b1;
      pend_op[i] = op;
      pend_a[i]  = a;
      pend_b[i]  = b;
   endtask

   task automatic drive_bus();
      for (int i = 0; i < NREQ; i++) begin
         bus.req_valid[i]         = pend_v[i];
         bus.req_opcode[i*5 +: 5] = pend_op[i];
         bus.req_a[i*32 +: 32]    = pend_a[i];
         bus.req_b[i*32 +: 32]    = pend_b[i];
      end
   endtask

   task automatic step();
      int              g;
      bit              exp_en, exp_rv, hs_req, hs_rsp;
      logic [NREQ-1:0] exp_gnt;
      if (rand_fill)
         for (int i = 0; i < NREQ; i++)
            if (!pend_v[i] && $urandom_range(0, 99) < 30)
               set_req(i, ($urandom_range(0, 1) == 1) ? 5'(8 + $urandom_range(0, 5))
                                                     : 5'($urandom_range(0, 31)),
                       $urandom, $urandom);
      exp_en = inflight && m_legal && cyc >= acc_cyc + 1 && cyc <= acc_cyc + int'(ALU_LAT);
      exp_rv = inflight && cyc >= acc_cyc + (m_legal ? int'(ALU_LAT) + 1 : 1);
      g = -1;
      if (!inflight)
         for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (rr_m + k) % NREQ;
            if (g < 0 && pend_v[idx]) g = idx;
         end
      exp_gnt = '0;
      if (g >= 0) exp_gnt[g] = 1'b1;
      case (rdy_mode)
         1:       bus.rsp_ready = 1'($urandom_range(0, 1));
         2: begin
            if (exp_rv && stall_cnt > 0) begin
               bus.rsp_ready = 1'b0;
               stall_cnt--;
            end else bus.rsp_ready = 1'b1;
         end
         default: bus.rsp_ready = 1'b1;
      endcase
      drive_bus();
      #1;
      check("req_ready", bus.req_ready, exp_gnt);
      check("busy", busy, inflight);
      check("alu_enable", bus.alu_enable, exp_en);
      check("rsp_valid", bus.rsp_valid, exp_rv);
      check("alu_opcode", bus.alu_opcode, last_op);
      check("alu_a", bus.alu_a, last_a);
      check("alu_b", bus.alu_b, last_b);
      if (exp_rv) begin
         check("rsp_id", bus.rsp_id, m_id);
         check("rsp_data", bus.rsp_data, m_data);
         check("rsp_err", bus.rsp_err, !m_legal);
      end
      hs_req = (g >= 0) && !rst;
      hs_rsp = exp_rv && bus.rsp_ready && !rst;
      if (!rst && (bus.req_valid & bus.req_ready) != '0)
         for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) grant_log.push_back(i);
      if (!rst && bus.rsp_valid && bus.rsp_ready) rsp_log.push_back(int'(bus.rsp_id));
      @(posedge clk);
      @(negedge clk);
      if (rst) begin
         inflight = 0;
         rr_m     = 0;
         last_op  = '0;
         last_a   = '0;
         last_b   = '0;
      end else begin
         if (hs_rsp) inflight = 0;
         if (hs_req) begin
            inflight = 1;
            acc_cyc  = cyc;
            m_id     = g;
            m_legal  = (pend_op[g] >= 5'd8) && (pend_op[g] <= 5'd13);
            m_data   = m_legal ? ref_alu(pend_op[g], pend_a[g], pend_b[g]) : 32'h0;
            if (m_legal) begin
               last_op = pend_op[g];
               last_a  = pend_a[g];
               last_b  = pend_b[g];
            end
            rr_m      = (g + 1) % NREQ;
            pend_v[g] = 1'b0;
            if (refill_xor) set_req(g, 5'd10, $urandom, $urandom);
         end
      end
      cyc++;
   endtask

   task automatic run_until_idle(input int max_cyc);
      bit any;
      int n;
      n = 0;
      any = 1'b1;
      while (any && n < max_cyc) begin
         step();
         n++;
         any = inflight;
         for (int i = 0; i < NREQ; i++) any = any | pend_v[i];
      end
      check("drain_busy", busy, 1'b0);
      check("drain_pending", any, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic chk_reset_vals();
      check("rst_alu_opcode", bus.alu_opcode, 0);
      check("rst_alu_a", bus.alu_a, 0);
      check("rst_alu_b", bus.alu_b, 0);
      check("rst_alu_enable", bus.alu_enable, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_data", bus.rsp_data, 0);
      check("rst_rsp_id", bus.rsp_id, 0);
      check("rst_rsp_err", bus.rsp_err, 0);
      check("rst_busy", busy, 0);
   endtask

   task automatic check_log(input string tag, input int q[$], input int exp[]);
      for (int k = 0; k < exp.size(); k++)
         check($sformatf("%s%0d", tag, k), (q.size() > k) ? q[k] : -1, exp[k]);
   endtask

   initial begin
      int exp_rr[] = '{0, 1, 2, 3, 0};
      int exp_wrap[] = '{2, 3, 1};
      int exp_rst[] = '{2, 1, 3};
      for (int i = 0; i < NREQ; i++) begin
         pend_v[i]  = 1'b0;
         pend_op[i] = '0;
         pend_a[i]  = '0;
         pend_b[i]  = '0;
      end
      rst = 1'b1;
      bus.rsp_ready = 1'b1;
      drive_bus();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_reset_vals();

      // Single AND from requester 0
      set_req(0, OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
      run_until_idle(20);
      check("and_rsp_data", bus.rsp_data, 32'hF000_F000);

      // Round-robin with all requesters continuously holding XOR
      do_reset();
      grant_log.delete();
      rsp_log.delete();
      refill_xor = 1;
      for (int i = 0; i < NREQ; i++) set_req(i, OP_XOR, $urandom, $urandom);
      for (int n = 0; n < 60 && rsp_log.size() < 5; n++) step();
      refill_xor = 0;
      run_until_idle(100);
      check_log("rr_grant", grant_log, exp_rr);
      check_log("rr_rsp_id", rsp_log, exp_rr);

      // Illegal opcode from requester 2
      set_req(2, 5'd0, $urandom, $urandom);
      run_until_idle(20);

      // Backpressure on NOR while another request waits
      rdy_mode  = 2;
      stall_cnt = 5;
      set_req(0, OP_NOR, 32'h0, 32'h0);
      set_req(1, OP_OR, $urandom, $urandom);
      run_until_idle(40);
      rdy_mode = 0;

      // Reset during the first EXEC cycle drops the op and clears rr
      grant_log.delete();
      set_req(2, OP_AND, $urandom, $urandom);
      for (int n = 0; n < 20 && !(inflight && cyc == acc_cyc + 1); n++) step();
      check("exec_before_rst", bus.alu_enable, 1'b1);
      do_reset();
      chk_reset_vals();
      set_req(1, OP_XNOR, $urandom, $urandom);
      set_req(3, OP_NAND, $urandom, $urandom);
      run_until_idle(40);
      check_log("rst_grant", grant_log, exp_rst);

      // Pointer wrap: rr lands on 3, then req3 beats req1
      grant_log.delete();
      set_req(2, 5'd31, $urandom, $urandom);
      run_until_idle(20);
      set_req(1, OP_OR, $urandom, $urandom);
      set_req(3, OP_XOR, $urandom, $urandom);
      run_until_idle(40);
      check_log("wrap_grant", grant_log, exp_wrap);

      // Random traffic with random response backpressure
      rand_fill = 1;
      rdy_mode  = 1;
      for (int n = 0; n < 400; n++) step();
      rand_fill = 0;
      rdy_mode  = 0;
      run_until_idle(200);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
